branch_update_ctrl: RTL and testbench

BRANCH_UPDATE_CTRL -- requirements
Module: branch_update_ctrl

---
 rtl/branch_update_ctrl_pkg.sv | 34 +++
 rtl/branch_update_ctrl_if.sv | 55 +++++
 rtl/branch_update_fifo.sv | 77 +++++++
 rtl/branch_update_ctrl.sv | 99 +++++++++
 tb/tb_branch_update_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/branch_update_ctrl_pkg.sv
// +-----------------------------------------------------------------------------+
// | branch_update_ctrl_pkg -- shared predictor defines and update-entry types   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package branch_update_ctrl_pkg;

  localparam int IDX_W         = 6;
  localparam int DEPTH_DEFAULT = 4;
  localparam int ENTRY_W       = 33;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } upd_entry_t;

  // Fetch must restart on the path the branch actually took.
  function automatic logic [31:0] redirect_target(input logic        taken,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_update_ctrl_if.sv
// +-----------------------------------------------------------------------------+
// | branch_update_ctrl_if -- EX resolution, predictor update, redirect, stats   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface branch_update_ctrl_if
  import branch_update_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
);

  logic                     res_valid;
  logic [31:0]              res_pc;
  logic                     res_taken;
  logic                     res_predicted;
  logic [31:0]              res_target;
  logic                     res_ready;

  logic                     upd_allow;
  logic                     upd_enable;
  logic [31:0]              upd_pc;
  logic                     upd_taken;

  logic                     redirect_valid;
  logic [31:0]              redirect_pc;

  logic                     clr_stats;
  logic [31:0]              branch_count;
  logic [31:0]              mispredict_count;
  logic [$clog2(DEPTH):0]   occupancy;

  modport slave (
    input  res_valid, res_pc, res_taken, res_predicted, res_target,
    output res_ready,
    input  upd_allow,
    output upd_enable, upd_pc, upd_taken,
    output redirect_valid, redirect_pc,
    input  clr_stats,
    output branch_count, mispredict_count, occupancy
  );

  modport master (
    output res_valid, res_pc, res_taken, res_predicted, res_target,
    input  res_ready,
    output upd_allow,
    input  upd_enable, upd_pc, upd_taken,
    input  redirect_valid, redirect_pc,
    output clr_stats,
    input  branch_count, mispredict_count, occupancy
  );

endinterface

`default_nettype wire

// File: rtl/branch_update_fifo.sv
// +-----------------------------------------------------------------------------+
// | branch_update_fifo -- pending predictor-update queue, registered read side  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module branch_update_fifo
  import branch_update_ctrl_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int DATA_W = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              w_push, w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (w_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/branch_update_ctrl.sv
// +-----------------------------------------------------------------------------+
// | branch_update_ctrl -- queues resolved branches for the predictor, redirects |
// | fetch on misprediction and keeps branch statistics.  Rev 1.0                |
// +-----------------------------------------------------------------------------+
`default_nettype none

module branch_update_ctrl
  import branch_update_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_update_ctrl_if.slave  bus
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic             w_full, w_empty, w_ready, w_accept, w_pop, w_mispredict;
  logic [CW-1:0]    w_count;
  upd_entry_t       w_head, w_tail;

  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [31:0]      branch_count_q, branch_count_d;
  logic [31:0]      mispredict_count_q, mispredict_count_d;

  assign w_ready      = !rst && !w_full;
  assign w_accept     = bus.res_valid && w_ready;
  assign w_pop        = !rst && !w_empty && bus.upd_allow;
  assign w_mispredict = (bus.res_taken != bus.res_predicted);
  assign w_tail       = '{pc: bus.res_pc, taken: bus.res_taken};

  branch_update_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_accept),
    .pop_i   (w_pop),
    .wdata_i (w_tail),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign bus.res_ready        = w_ready;
  assign bus.upd_enable       = w_pop;
  assign bus.upd_pc           = (rst || w_empty) ? '0 : w_head.pc;
  assign bus.upd_taken        = (rst || w_empty) ? 1'b0 : w_head.taken;
  assign bus.occupancy        = w_count;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  always_comb begin
    redirect_valid_d = w_accept && w_mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (redirect_valid_d) begin
      redirect_pc_d = redirect_target(bus.res_taken, bus.res_pc, bus.res_target);
    end
  end

  // A clear wins over an increment landing in the same cycle.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (bus.clr_stats) begin
      branch_count_d     = '0;
      mispredict_count_d = '0;
    end else if (w_accept) begin
      if (branch_count_q != CNT_MAX) branch_count_d = branch_count_q + 32'd1;
      if (w_mispredict && (mispredict_count_q != CNT_MAX)) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_update_ctrl.sv
// +-----------------------------------------------------------------------------+
// | tb_branch_update_ctrl -- scoreboard bench for branch_update_ctrl            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_branch_update_ctrl;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_update_ctrl_if #(.DEPTH(DEPTH)) bus ();

  branch_update_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [32:0] exp_upd[$];
  logic [31:0] exp_redir[$];
  logic [31:0] last_redir = '0;
  logic [31:0] m_br = '0;
  logic [31:0] m_mp = '0;
  bit          model_ready = 1'b0;
  bit          stim_done = 1'b0;
  int          total = 0;
  int          bad = 0;

  int          mon_sz;
  bit          mon_rdy, mon_en;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic step(input logic v, input logic [31:0] pc, input logic tk, input logic pr,
                      input logic [31:0] tg, input logic al, input logic cl, input logic r);
    logic        acc;
    logic [31:0] nr;
    bus.res_valid     = v;
    bus.res_pc        = pc;
    bus.res_taken     = tk;
    bus.res_predicted = pr;
    bus.res_target    = tg;
    bus.upd_allow     = al;
    bus.clr_stats     = cl;
    rst               = r;
    @(posedge clk);
    acc = v && model_ready;
    if (r) begin
      exp_upd.delete();
      exp_redir.delete();
      last_redir = '0;
      m_br       = '0;
      m_mp       = '0;
    end else begin
      if (acc) begin
        exp_upd.push_back({pc, tk});
        if (tk != pr) begin
          nr         = tk ? tg : pc + 32'd4;
          last_redir = nr;
          exp_redir.push_back(nr);
        end
      end
      if (cl) begin
        m_br = '0;
        m_mp = '0;
      end else if (acc) begin
        if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        if (tk != pr && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic al);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, al, 1'b0, 1'b0);
  endtask

  // Monitor: compares every DUT output on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      mon_sz  = exp_upd.size();
      mon_rdy = !rst && (mon_sz < DEPTH);
      mon_en  = !rst && (mon_sz > 0) && bus.upd_allow;
      chk("res_ready", bus.res_ready, mon_rdy);
      model_ready = mon_rdy;
      chk("upd_enable", bus.upd_enable, mon_en);
      if (!rst && mon_sz > 0) begin
        chk("upd_pc", bus.upd_pc, exp_upd[0][32:1]);
        chk("upd_taken", bus.upd_taken, exp_upd[0][0]);
      end else begin
        chk("upd_pc_zero", bus.upd_pc, 0);
        chk("upd_taken_zero", bus.upd_taken, 0);
      end
      if (mon_en) void'(exp_upd.pop_front());
      chk("occupancy", bus.occupancy, mon_sz);
      chk("redirect_valid", bus.redirect_valid, exp_redir.size() > 0);
      chk("redirect_pc", bus.redirect_pc, last_redir);
      if (exp_redir.size() > 0) chk("redirect_pc_evt", bus.redirect_pc, exp_redir.pop_front());
      chk("branch_count", bus.branch_count, m_br);
      chk("mispredict_count", bus.mispredict_count, m_mp);
    end
  end

  initial begin
    bus.res_valid = 1'b0; bus.res_pc = '0; bus.res_taken = 1'b0; bus.res_predicted = 1'b0;
    bus.res_target = '0; bus.upd_allow = 1'b0; bus.clr_stats = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);

    // Single correctly predicted branch.
    step(1'b1, 32'h100, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Two mispredictions: taken path and fall-through path.
    step(1'b1, 32'h200, 1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h204, 1'b0, 1'b1, 32'h999, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // Fill with the update port blocked, then one extra attempt, then drain.
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b1, 32'h1000 + 32'(i * 4), i[0], 1'b0, 32'h4000, 1'b0, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Full queue with coincident pop and res_valid, then sustained traffic across wrap.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'h2000 + 32'(i * 4), 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2F00, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 99) < 80, $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom(), $urandom_range(0, 99) < 60, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Reset with entries pending, then a clear coincident with an accept.
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h3000 + 32'(i * 4), 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    step(1'b1, 32'h500, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h504, 1'b1, 1'b0, 32'h40, 1'b1, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 99) < 60, $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom(), $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    idle(DEPTH + 3, 1'b1);

    stim_done = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
